// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - debouncer state type, default timing constants and a width helper
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int DEF_STABLE_TICKS = 20;
  localparam int DEF_REPEAT_DELAY = 500;
  localparam int DEF_REPEAT_RATE  = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_debounce_if.sv
// rtl/tick_debounce_if.sv - sampling strobe, raw button and debounced outputs of one button channel
interface tick_debounce_if;

  logic tick;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  modport master (
    output tick, btn_in,
    input  btn_level, btn_press, btn_release
  );

  modport slave (
    input  tick, btn_in,
    output btn_level, btn_press, btn_release
  );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, asynchronous reset to 0
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tick_debounce.sv
// rtl/tick_debounce.sv - tick-sampled push-button debouncer with registered level and press/release strobes
// Optional auto-repeat of btn_press while held: define DEBOUNCE_REPEAT_EN.
module tick_debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input logic            clk,
  input logic            rst,
  tick_debounce_if.slave bus
);

  localparam int            CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam bit            SINGLE   = (STABLE_TICKS == 1);

  if (STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("tick_debounce: STABLE_TICKS, REPEAT_DELAY and REPEAT_RATE must all be at least 1");
  end

  db_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_r, level_n;
  logic          press_r, press_n;
  logic          release_r, release_n;
  logic          accept_press, accept_release;
  logic          s;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int            RW         = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rcnt, rcnt_n;
  logic          fired, fired_n;
  logic          rep_hit;

  // The first repeat waits the long delay, later ones the shorter rate.
  assign rep_hit = (rcnt == (fired ? RATE_LAST : DELAY_LAST));
`endif

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      rcnt      <= '0;
      fired     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      level_r   <= level_n;
      press_r   <= press_n;
      release_r <= release_n;
`ifdef DEBOUNCE_REPEAT_EN
      rcnt      <= rcnt_n;
      fired     <= fired_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    level_n        = level_r;
    press_n        = 1'b0;
    release_n      = 1'b0;
    accept_press   = 1'b0;
    accept_release = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    rcnt_n         = rcnt;
    fired_n        = fired;
`endif
    if (bus.tick) begin
      case (state)
        IDLE: begin
          if (s) begin
            if (SINGLE) begin
              accept_press = 1'b1;
            end else begin
              state_n = PRESS_WAIT;
              cnt_n   = CNT_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            accept_press = 1'b1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            if (SINGLE) begin
              accept_release = 1'b1;
            end else begin
              state_n = RELEASE_WAIT;
              cnt_n   = CNT_ONE;
            end
          end
`ifdef DEBOUNCE_REPEAT_EN
          else if (rep_hit) begin
            press_n = 1'b1;
            rcnt_n  = '0;
            fired_n = 1'b1;
          end else begin
            rcnt_n = rcnt + RW'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          // A bounce back to 1 resumes HELD silently; the repeat timer keeps its place.
          if (s) begin
            state_n = HELD;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            accept_release = 1'b1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase

      if (accept_press) begin
        state_n = HELD;
        level_n = 1'b1;
        press_n = 1'b1;
        cnt_n   = '0;
`ifdef DEBOUNCE_REPEAT_EN
        rcnt_n  = '0;
        fired_n = 1'b0;
`endif
      end
      if (accept_release) begin
        state_n   = IDLE;
        level_n   = 1'b0;
        release_n = 1'b1;
        cnt_n     = '0;
      end
    end
  end

  assign bus.btn_level   = level_r;
  assign bus.btn_press   = press_r;
  assign bus.btn_release = release_r;

endmodule

// File: tb/tb_tick_debounce.sv
// tb/tb_tick_debounce.sv - self-checking bench for tick_debounce (STABLE_TICKS=4, REPEAT_DELAY=6, REPEAT_RATE=3)
module tb_tick_debounce;

  localparam int STABLE = 4;
  localparam int DELAY  = 6;
  localparam int RATE   = 3;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    int div;
    bit btn;
    int cycles;
    bit exp_level;
    int exp_press;
    int exp_rel;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  tick_debounce_if bus ();

  tick_debounce #(
    .STABLE_TICKS (STABLE),
    .REPEAT_DELAY (DELAY),
    .REPEAT_RATE  (RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int tick_div = 1;

  // Reference: the debounced level flips once STABLE consecutive ticks disagree with it.
  bit m_d1, m_d2, m_level, m_press, m_rel;
  int m_run, m_hold;

  vec_t vecs[$];
  int np, nr, found;
  bit [20:0] got_mask, exp_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    m_run = 0; m_hold = 0;
  endtask

  task automatic model_edge(input bit b, input bit t);
    bit s, pending;
    s = m_d2; m_d2 = m_d1; m_d1 = b;
    m_press = 1'b0; m_rel = 1'b0;
    if (t) begin
      if (s != m_level) begin
        m_run++;
        if (m_run == STABLE) begin
          m_level = s;
          m_run   = 0;
          if (s) begin m_press = 1'b1; m_hold = 0; end
          else m_rel = 1'b1;
        end
      end else begin
        pending = (m_run != 0);
        m_run   = 0;
        if (REP && m_level && !pending) begin
          m_hold++;
          if (m_hold == DELAY || (m_hold > DELAY && (m_hold - DELAY) % RATE == 0)) m_press = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit b);
    bus.btn_in = b;
    bus.tick   = (tick_div <= 1) || (cyc % tick_div == 0);
    if (rst) model_reset();
    else model_edge(b, bus.tick);
    @(posedge clk);
    #1;
    cyc++;
    check("model", {29'd0, bus.btn_level, bus.btn_press, bus.btn_release},
          {29'd0, m_level, m_press, m_rel});
    check("exclusive", 32'(bus.btn_press & bus.btn_release), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.btn_in = 1'b0;
    bus.tick   = 1'b0;
    #1;
    check("reset_level", bus.btn_level, 0);
    check("reset_press", bus.btn_press, 0);
    check("reset_release", bus.btn_release, 0);
    model_reset();
    repeat (3) step(1'b0);
    rst = 1'b0;

    // Clean press, tick tied high: raised at cycle 10, accepted 6 edges later.
    tick_div = 1;
    while (cyc < 10) step(1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1);
      if (i == 5) check("t1_level_early", bus.btn_level, 0);
      if (i == 6) begin
        check("t1_level", bus.btn_level, 1);
        check("t1_press", bus.btn_press, 1);
      end
      if (i == 7) check("t1_press_end", bus.btn_press, 0);
    end
    repeat (10) step(1'b0);

    vecs.push_back('{1, 1'b0,  8, 1'b0, 0, 0});
    vecs.push_back('{1, 1'b1,  2, 1'b0, 0, 0});
    vecs.push_back('{1, 1'b0,  2, 1'b0, 0, 0});
    vecs.push_back('{1, 1'b1, 10, 1'b1, 1, 0});
    vecs.push_back('{1, 1'b0,  3, 1'b1, int'(REP), 0});
    vecs.push_back('{1, 1'b1,  3, 1'b1, 0, 0});
    vecs.push_back('{1, 1'b0, 10, 1'b0, 0, 1});
    vecs.push_back('{5, 1'b1, 12, 1'b0, 0, 0});
    vecs.push_back('{5, 1'b0, 15, 1'b0, 0, 0});
    vecs.push_back('{5, 1'b1, 30, 1'b1, 1, 0});
    vecs.push_back('{5, 1'b0, 30, 1'b0, 0, 1});
    foreach (vecs[v]) begin
      tick_div = vecs[v].div;
      np = 0;
      nr = 0;
      repeat (vecs[v].cycles) begin
        step(vecs[v].btn);
        np += int'(bus.btn_press);
        nr += int'(bus.btn_release);
      end
      check($sformatf("vec%0d_level", v), bus.btn_level, vecs[v].exp_level);
      check($sformatf("vec%0d_presses", v), np, vecs[v].exp_press);
      check($sformatf("vec%0d_releases", v), nr, vecs[v].exp_rel);
    end

    // Long hold: strobe pattern relative to acceptance.
    tick_div = 1;
    found    = -1;
    for (int i = 1; i <= 20 && found < 0; i++) begin
      step(1'b1);
      if (bus.btn_press) found = i;
    end
    check("t6_accept_latency", found, 6);
    got_mask = (found >= 0) ? 21'd1 : 21'd0;
    exp_mask = 21'd1;
    if (REP) exp_mask |= (21'd1 << 6) | (21'd1 << 9) | (21'd1 << 12) | (21'd1 << 15) | (21'd1 << 18);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1);
      if (bus.btn_press) got_mask[k] = 1'b1;
    end
    check("t6_repeat_pattern", got_mask, exp_mask);

    // Asynchronous reset while held, button still down afterwards.
    rst = 1'b1;
    #1;
    check("t5_rst_level", bus.btn_level, 0);
    check("t5_rst_press", bus.btn_press, 0);
    check("t5_rst_release", bus.btn_release, 0);
    model_reset();
    repeat (2) step(1'b1);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step(1'b1);
      if (i == 5) check("t5_level_early", bus.btn_level, 0);
      if (i == 6) check("t5_press", bus.btn_press, 1);
      if (i == 7) check("t5_press_end", bus.btn_press, 0);
    end

    // Random bouncing against the reference, with occasional resets.
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      bit b;
      tick_div = ($urandom_range(0, 2) == 0) ? 1 + $urandom_range(1, 4) : 1;
      b        = 1'($urandom_range(0, 1));
      len      = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : $urandom_range(6, 40);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        #1;
        check("rand_rst", {29'd0, bus.btn_level, bus.btn_press, bus.btn_release}, 32'd0);
        model_reset();
        step(b);
        rst = 1'b0;
      end
      repeat (len) step(b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
